// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - prioritized edge-triggered interrupt controller with MMIO registers
// Nesting of higher-priority sources during service is enabled by defining IRQ_CTRL_NEST_EN.
module irq_ctrl #(
  parameter int          N_SRC      = 4,
  parameter logic [15:0] VEC_BASE   = 16'h0100,
  parameter logic [15:0] VEC_STRIDE = 16'h0010
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_SRC-1:0] i_irq_src,
  input  logic             i_sel,
  input  logic             i_we,
  input  logic             i_re,
  input  logic [1:0]       i_addr,
  input  logic [15:0]      i_wdata,
  output logic [15:0]      o_rdata,
  input  logic             i_cpu_ready,
  input  logic             i_iret,
  output logic             o_irq_take,
  output logic [15:0]      o_irq_vector,
  output logic             o_in_irq
);
  typedef enum logic [1:0] {S_IDLE, S_TAKE, S_INSVC} state_t;

  localparam logic [1:0] A_ENABLE  = 2'b00;
  localparam logic [1:0] A_PENDING = 2'b01;
  localparam logic [1:0] A_CTRL    = 2'b10;
  localparam logic [N_SRC-1:0] LSB = {{(N_SRC-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [N_SRC-1:0] enable_q, enable_d;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] isr_q, isr_d;
  logic [N_SRC-1:0] src_q, src_d;
  logic             gie_q, gie_d;
  logic [15:0]      vector_q, vector_d;

  logic [N_SRC-1:0] cand, win_oh, rise, w1c;
  logic [15:0]      win_idx;
  logic             take_go, wr_en, unused_wdata;

  assign unused_wdata = ^i_wdata;
  assign wr_en        = i_sel & i_we;
  assign cand         = pending_q & enable_q;
  // Isolate the lowest set bit: that is the highest-priority candidate.
  assign win_oh       = cand & (~cand + LSB);

  always_comb begin
    win_idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (cand[i]) win_idx = 16'(i);
    end
  end

`ifdef IRQ_CTRL_NEST_EN
  logic [15:0] isr_idx;
  always_comb begin
    isr_idx = '1;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (isr_q[i]) isr_idx = 16'(i);
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    enable_d = enable_q;
    gie_d    = gie_q;
    isr_d    = isr_q;
    vector_d = vector_q;
    src_d    = i_irq_src;
    rise     = i_irq_src & ~src_q;
    w1c      = '0;
    take_go  = 1'b0;

    case (state_q)
      S_IDLE: begin
        take_go = gie_q & i_cpu_ready & (|cand);
        if (take_go) state_d = S_TAKE;
      end
      S_TAKE: state_d = S_INSVC;
      S_INSVC: begin
`ifdef IRQ_CTRL_NEST_EN
        take_go = gie_q & i_cpu_ready & (|cand) & (win_idx < isr_idx);
`endif
        if (i_iret) isr_d = isr_q & (isr_q - LSB);
        if (take_go) state_d = S_TAKE;
        else if (isr_d == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (take_go) begin
      vector_d = VEC_BASE + win_idx * VEC_STRIDE;
      isr_d    = isr_d | win_oh;
    end

    if (wr_en) begin
      case (i_addr)
        A_ENABLE:  enable_d = i_wdata[N_SRC-1:0];
        A_PENDING: w1c      = i_wdata[N_SRC-1:0];
        A_CTRL:    gie_d    = i_wdata[0];
        default:   ;
      endcase
    end

    // A fresh edge always beats a software or take clear on the same bit.
    pending_d = (pending_q & ~w1c & ~({N_SRC{take_go}} & win_oh)) | rise;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      enable_q  <= '0;
      pending_q <= '0;
      isr_q     <= '0;
      src_q     <= '0;
      gie_q     <= 1'b0;
      vector_q  <= 16'h0000;
    end else begin
      state_q   <= state_d;
      enable_q  <= enable_d;
      pending_q <= pending_d;
      isr_q     <= isr_d;
      src_q     <= src_d;
      gie_q     <= gie_d;
      vector_q  <= vector_d;
    end
  end

  assign o_irq_take   = (state_q == S_TAKE);
  assign o_irq_vector = vector_q;
  assign o_in_irq     = |isr_q;

  always_comb begin
    o_rdata = 16'h0000;
    if (i_sel && i_re) begin
      case (i_addr)
        A_ENABLE:  o_rdata[N_SRC-1:0] = enable_q;
        A_PENDING: o_rdata[N_SRC-1:0] = pending_q;
        A_CTRL:    o_rdata[0]         = gie_q;
        default: begin
          o_rdata[N_SRC-1:0] = isr_q;
          o_rdata[15]        = o_in_irq;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - self-checking bench for irq_ctrl (tables, directed sequences, random vs model)
module tb_irq_ctrl;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [N-1:0] src;
  logic        sel, we, re;
  logic [1:0]  addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        cpu_ready, iret;
  logic        take;
  logic [15:0] vector;
  logic        in_irq;

  always #5 clk = ~clk;

  irq_ctrl #(.N_SRC(N), .VEC_BASE(16'h0100), .VEC_STRIDE(16'h0010)) dut (
    .i_clk(clk), .i_rst(rst), .i_irq_src(src),
    .i_sel(sel), .i_we(we), .i_re(re), .i_addr(addr), .i_wdata(wdata),
    .o_rdata(rdata), .i_cpu_ready(cpu_ready), .i_iret(iret),
    .o_irq_take(take), .o_irq_vector(vector), .o_in_irq(in_irq)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    step();
    sel = 1'b0; we = 1'b0; wdata = 16'h0000;
  endtask

  task automatic rd(input logic [1:0] a, output logic [15:0] d);
    sel = 1'b1; re = 1'b1; addr = a;
    #1;
    d = rdata;
    sel = 1'b0; re = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; src = '0; sel = 1'b0; we = 1'b0; re = 1'b0; addr = 2'b00;
    wdata = 16'h0000; iret = 1'b0; cpu_ready = 1'b1;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic wait_take(input int max, output int n);
    bit found;
    found = 1'b0;
    n = 0;
    for (int i = 1; i <= max; i++) begin
      if (!found) begin
        step();
        if (take) begin found = 1'b1; n = i; end
      end
    end
  endtask

  task automatic count_takes(input int cycles, output int c);
    c = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (take) c++;
    end
  endtask

  task automatic pulse_iret();
    iret = 1'b1;
    step();
    iret = 1'b0;
  endtask

  // Reference model: ENABLE/PENDING/GIE as bit vectors, in-service sources as a list.
  logic [3:0]  m_en, m_pend, m_prev;
  logic        m_gie, m_take;
  logic [15:0] m_vec;
  int          m_svc[$];

  task automatic model_reset();
    m_en = '0; m_pend = '0; m_prev = '0; m_gie = 1'b0; m_take = 1'b0; m_vec = 16'h0000;
    m_svc.delete();
  endtask

  function automatic logic [15:0] model_rd(input logic [1:0] a);
    logic [15:0] r;
    r = 16'h0000;
    case (a)
      2'd0: r[3:0] = m_en;
      2'd1: r[3:0] = m_pend;
      2'd2: r[0] = m_gie;
      default: begin
        foreach (m_svc[i]) r[m_svc[i]] = 1'b1;
        r[15] = (m_svc.size() != 0);
      end
    endcase
    return r;
  endfunction

  task automatic model_step(input logic [3:0] s, input logic rdy, input logic ir,
                            input logic w, input logic [1:0] a, input logic [15:0] d);
    logic [3:0] rise, cand;
    int k, mn, mi;
    logic go;
    rise = s & ~m_prev;
    cand = m_pend & m_en;
    k = -1;
    for (int i = 3; i >= 0; i--) if (cand[i]) k = i;
    mn = 99; mi = -1;
    foreach (m_svc[i]) if (m_svc[i] < mn) begin mn = m_svc[i]; mi = i; end
    go = 1'b0;
    if (!m_take && m_gie && rdy && k >= 0) begin
      if (m_svc.size() == 0) go = 1'b1;
`ifdef IRQ_CTRL_NEST_EN
      else if (k < mn) go = 1'b1;
`endif
    end
    if (!m_take && mi >= 0 && ir) m_svc.delete(mi);
    if (go) begin
      m_svc.push_back(k);
      m_vec = 16'(16'h0100 + k * 16);
      m_pend[k] = 1'b0;
    end
    m_take = go;
    if (w) begin
      case (a)
        2'd0: m_en = d[3:0];
        2'd1: m_pend = m_pend & ~d[3:0];
        2'd2: m_gie = d[0];
        default: ;
      endcase
    end
    m_pend = m_pend | rise;
    m_prev = s;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } reg_vec_t;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reg_vec_t    tbl[10];
    logic [15:0] d;
    int          n, c;
    logic [3:0]  ns;
    logic        nw, nr;
    logic [1:0]  na;
    logic [15:0] nd;
    int          op;

    tbl[0] = '{1'b0, 2'd0, 16'h0000, 16'h0000};
    tbl[1] = '{1'b0, 2'd1, 16'h0000, 16'h0000};
    tbl[2] = '{1'b0, 2'd2, 16'h0000, 16'h0000};
    tbl[3] = '{1'b0, 2'd3, 16'h0000, 16'h0000};
    tbl[4] = '{1'b1, 2'd0, 16'hFFFF, 16'h000F};
    tbl[5] = '{1'b1, 2'd2, 16'hFFFF, 16'h0001};
    tbl[6] = '{1'b1, 2'd3, 16'hFFFF, 16'h0000};
    tbl[7] = '{1'b1, 2'd0, 16'h0005, 16'h0005};
    tbl[8] = '{1'b1, 2'd1, 16'hFFFF, 16'h0000};
    tbl[9] = '{1'b1, 2'd2, 16'h0002, 16'h0000};

    do_reset();
    chk("reset_take", 16'(take), 16'h0000);
    chk("reset_vector", vector, 16'h0000);
    chk("reset_in_irq", 16'(in_irq), 16'h0000);

    for (int i = 0; i < 10; i++) begin
      if (tbl[i].we) wr(tbl[i].addr, tbl[i].wdata);
      rd(tbl[i].addr, d);
      chk($sformatf("regmap_%0d", i), d, tbl[i].exp);
    end
    sel = 1'b1; addr = 2'd0; #1;
    chk("rdata_zero_without_re", rdata, 16'h0000);
    sel = 1'b0;

    // Single source: latency, vector, one-cycle pulse, level hold does not re-pend.
    do_reset();
    wr(2'd0, 16'h0001); wr(2'd2, 16'h0001);
    src = 4'b0001;
    wait_take(4, n);
    chk("t035_latency", 16'(n), 16'd2);
    chk("t035_vector", vector, 16'h0100);
    step();
    chk("t035_take_one_cycle", 16'(take), 16'h0000);
    chk("t035_in_irq", 16'(in_irq), 16'h0001);
    rd(2'd1, d);
    chk("t035_pending_cleared", d, 16'h0000);
    pulse_iret();
    chk("t035_in_irq_after_iret", 16'(in_irq), 16'h0000);
    count_takes(4, c);
    chk("t035_level_no_repend", 16'(c), 16'h0000);

    // Two simultaneous sources, priority order and sequential service.
    wr(2'd0, 16'h0006);
    src = 4'b0110;
    wait_take(4, n);
    chk("t036_first_seen", 16'(n != 0), 16'h0001);
    chk("t036_first_vector", vector, 16'h0110);
    step();
    pulse_iret();
    wait_take(4, n);
    chk("t036_second_seen", 16'(n != 0), 16'h0001);
    chk("t036_second_vector", vector, 16'h0120);
    step();
    pulse_iret();
    chk("t036_in_irq_done", 16'(in_irq), 16'h0000);

    // GIE off: pending only, W1C.
    do_reset();
    wr(2'd0, 16'h0001);
    src = 4'b0001;
    count_takes(4, c);
    chk("t037_no_take", 16'(c), 16'h0000);
    rd(2'd1, d);
    chk("t037_pending_set", d, 16'h0001);
    wr(2'd1, 16'h0001);
    rd(2'd1, d);
    chk("t037_pending_w1c", d, 16'h0000);

    // Higher-priority arrival during service.
    do_reset();
    wr(2'd0, 16'h000F); wr(2'd2, 16'h0001);
    src = 4'b0100;
    wait_take(4, n);
    chk("t038_src2_vector", vector, 16'h0120);
    step();
    src = 4'b0101;
`ifdef IRQ_CTRL_NEST_EN
    wait_take(4, n);
    chk("t038_nest_seen", 16'(n != 0), 16'h0001);
    chk("t038_nest_vector", vector, 16'h0100);
    step();
    rd(2'd3, d);
    chk("t038_nest_status", d, 16'h8005);
`else
    count_takes(4, c);
    chk("t038_no_nest_take", 16'(c), 16'h0000);
    rd(2'd3, d);
    chk("t038_status", d, 16'h8004);
    rd(2'd1, d);
    chk("t038_pending", d, 16'h0001);
    pulse_iret();
    wait_take(4, n);
    chk("t038_deferred_vector", vector, 16'h0100);
`endif

    // W1C coinciding with a rising edge: the set wins.
    do_reset();
    src = 4'b0010; step();
    src = 4'b0000; step();
    rd(2'd1, d);
    chk("t039_pending_before", d, 16'h0002);
    sel = 1'b1; we = 1'b1; addr = 2'd1; wdata = 16'h0002; src = 4'b0010;
    step();
    sel = 1'b0; we = 1'b0; wdata = 16'h0000;
    rd(2'd1, d);
    chk("t039_set_wins", d, 16'h0002);
    wr(2'd1, 16'h0002);
    rd(2'd1, d);
    chk("t039_plain_w1c", d, 16'h0000);

    // Reset during service and during take.
    do_reset();
    wr(2'd0, 16'h0001); wr(2'd2, 16'h0001);
    src = 4'b0001;
    wait_take(4, n);
    step();
    chk("t040_in_service", 16'(in_irq), 16'h0001);
    rst = 1'b1; step(); rst = 1'b0;
    chk("t040_in_irq", 16'(in_irq), 16'h0000);
    chk("t040_take", 16'(take), 16'h0000);
    rd(2'd3, d);
    chk("t040_status", d, 16'h0000);
    count_takes(5, c);
    chk("t040_no_take", 16'(c), 16'h0000);
    wr(2'd0, 16'h0001); wr(2'd2, 16'h0001);
    wait_take(4, n);
    chk("t031_take_again", 16'(n != 0), 16'h0001);
    rst = 1'b1; step(); rst = 1'b0;
    chk("t031_in_irq", 16'(in_irq), 16'h0000);
    count_takes(5, c);
    chk("t031_no_take", 16'(c), 16'h0000);

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      chk("rand_take", 16'(take), 16'(m_take));
      chk("rand_vector", vector, m_vec);
      chk("rand_in_irq", 16'(in_irq), 16'(m_svc.size() != 0));
      ns = src ^ 4'($urandom & $urandom & $urandom);
      op = int'($urandom_range(0, 7));
      nw = (op == 0);
      nr = (op >= 1 && op <= 3);
      na = 2'($urandom);
      nd = 16'($urandom);
      if (nw && na == 2'd2) nd[0] = ($urandom_range(0, 3) != 0);
      src = ns;
      cpu_ready = ($urandom_range(0, 3) != 0);
      iret = ($urandom_range(0, 2) == 0);
      sel = nw | nr; we = nw; re = nr; addr = na; wdata = nd;
      if (nr) begin
        #1;
        chk("rand_rdata", rdata, model_rd(na));
      end
      model_step(ns, cpu_ready, iret, nw, na, nd);
      step();
    end
    sel = 1'b0; we = 1'b0; re = 1'b0; iret = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have parameter N_SRC, default 4: number of interrupt sources; index 0 has the highest priority.
REQ-002 SHALL have parameter VEC_BASE, default 16'h0100: vector of source 0.
REQ-003 SHALL have parameter VEC_STRIDE, default 16'h0010: vector spacing; vector = VEC_BASE + idx*VEC_STRIDE, modulo 2^16.
REQ-004 SHALL have port i_clk, input, 1: single system clock, rising edge.
REQ-005 SHALL have port i_rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port i_irq_src, input, N_SRC: level request lines (UART o_irq_req on bit 0, parallel port on bit 1).
REQ-007 SHALL have MMIO inputs i_sel (1), i_we (1), i_re (1), i_addr (2), i_wdata (16).
REQ-008 SHALL have port o_rdata, output, 16: MMIO read data.
REQ-009 SHALL have port i_cpu_ready, input, 1: CPU is at an instruction boundary.
REQ-010 SHALL have port i_iret, input, 1: single-cycle return-from-interrupt pulse.
REQ-011 SHALL have port o_irq_take, output, 1: single-cycle take pulse to the CPU.
REQ-012 SHALL have port o_irq_vector, output, 16: handler address, held until the next take.
REQ-013 SHALL have port o_in_irq, output, 1: high while any source is in service.

Function
REQ-014 SHALL implement the register map ENABLE at 2'b00 (RW, bits N_SRC-1:0), PENDING at 2'b01 (read; write-1-to-clear), CTRL at 2'b10 (bit0 GIE, RW), and STATUS at 2'b11 (RO: [N_SRC-1:0] ISR, bit 15 o_in_irq).
REQ-015 SHALL drive o_rdata combinationally when i_sel&i_re, with unused bits 0; otherwise o_rdata SHALL be 16'h0000.
REQ-016 SHALL commit register writes on the clock edge where i_sel&i_we; writes to STATUS SHALL be ignored.
REQ-017 SHALL set PENDING[k] on the cycle after i_irq_src[k] rises (0->1 versus its registered copy); a level held high SHALL not re-set PENDING once it is cleared.
REQ-018 SHALL let a set win when a rising edge, a write-1-to-clear and/or a take-clear coincide on the same bit.
REQ-019 SHALL define candidate = PENDING & ENABLE; winner = lowest set index of candidate.
REQ-020 SHALL implement FSM states IDLE, TAKE, INSVC.
REQ-021 SHALL go IDLE->TAKE when GIE & |candidate & i_cpu_ready.
REQ-022 SHALL, on the edge entering TAKE, latch o_irq_vector from winner, clear PENDING[winner] and set ISR[winner].
REQ-023 SHALL assert o_irq_take in TAKE for exactly one cycle; TAKE SHALL always go to INSVC next.
REQ-024 SHALL, in INSVC, clear the lowest set ISR bit on i_iret, and go to IDLE when ISR becomes zero, else stay in INSVC.
REQ-025 SHALL drive o_in_irq = |ISR, registered.
REQ-026 SHALL ignore i_iret in IDLE and in TAKE.
REQ-027 SHALL not affect an in-service source when ENABLE or GIE is cleared; it SHALL only block new takes.
REQ-028 SHALL take pending requests that arrive during INSVC only after return to IDLE (unless REQ-033 applies).
REQ-029 SHALL have worst-case latency from a source edge to o_irq_take of 2 cycles, given IDLE, GIE, enable and cpu_ready.

Reset
REQ-030 SHALL, while i_rst is high at a clock edge, clear ENABLE, PENDING, GIE, ISR and the edge registers, and set state IDLE, o_irq_take 0, o_irq_vector 16'h0000 and o_in_irq 0.
REQ-031 SHALL, on reset mid-service or mid-take, abandon the service with no further take pulse.

Configuration
REQ-032 SHALL use macro IRQ_CTRL_NEST_EN.
REQ-033 SHALL, when IRQ_CTRL_NEST_EN is defined, go INSVC->TAKE when GIE & i_cpu_ready and winner index < lowest set ISR index; ISR then holds multiple bits, and each i_iret pops the lowest.
REQ-034 SHALL, when IRQ_CTRL_NEST_EN is undefined, never assert o_irq_take while o_in_irq; ISR then has at most one bit set.

Verification
REQ-035 SHALL check: ENABLE=1, GIE=1, cpu_ready=1, src0 rises -> o_irq_take pulse of 1 cycle within 2 cycles, vector 16'h0100, o_in_irq=1, PENDING[0]=0.
REQ-036 SHALL check: src1 and src2 rise together, ENABLE=6 -> take vector 16'h0110; after i_iret, second take vector 16'h0120; after second i_iret, o_in_irq=0.
REQ-037 SHALL check: GIE=0, src0 edge -> PENDING reads 16'h0001, no take; write 16'h0001 to PENDING -> reads 16'h0000.
REQ-038 SHALL check: in service of src2, src0 edge -> no take with NEST_EN undefined; with NEST_EN defined -> take vector 16'h0100, STATUS ISR=4'b0101.
REQ-039 SHALL check: W1C on PENDING[1] coinciding with a src1 rising edge -> PENDING[1] reads 1.
REQ-040 SHALL check: i_rst pulse during INSVC -> o_in_irq=0, STATUS=16'h0000, no take before ENABLE and GIE are rewritten.
